// File: rtl/control_botones_pkg.sv
// Shared constants and types for the push-button front end of the grid game.
package control_botones_pkg;

  localparam int NUM_DIRS      = 4;
  localparam int DIR_ARRIBA    = 3;
  localparam int DIR_ABAJO     = 2;
  localparam int DIR_DERECHA   = 1;
  localparam int DIR_IZQUIERDA = 0;

  typedef logic [NUM_DIRS-1:0] dir_vec_t;

endpackage

// File: rtl/control_botones_antirrebote.sv
// One button: two-flop synchroniser, debounce counter, stable level and a
// single-cycle press event raised on the edge the stable level rises.
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic estable_o,
  output logic pulsacion_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          estable_q, estable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    estable_d = estable_q;
    cnt_d     = '0;
    if (sync2_q != estable_q) begin
      if (cnt_q == CNT_MAX) begin
        estable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      estable_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      estable_q <= estable_d;
      cnt_q     <= cnt_d;
    end
  end

  // The press event is combinational so the top can latch it on the same edge.
  assign pulsacion_o = estable_d & ~estable_q;
  assign estable_o   = estable_q;

endmodule

// File: rtl/control_botones.sv
// Four debounced buttons feeding a priority arbiter of one-cycle move pulses.
// Optional auto-repeat while held: define CONTROL_BOTONES_AUTO_REPEAT_EN.
module control_botones
  import control_botones_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                habilitar,
  input  logic [NUM_DIRS-1:0] btn,
  output logic                arriba,
  output logic                abajo,
  output logic                derecha,
  output logic                izquierda,
  output logic [NUM_DIRS-1:0] btn_estable
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("control_botones: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* >= 1");
  end

  dir_vec_t estable, pulsacion, repetir;
  dir_vec_t pend_q, pend_d;
  dir_vec_t salida_q, salida_d;

  for (genvar i = 0; i < NUM_DIRS; i++) begin : g_boton
    antirrebote #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_antirrebote (
      .clk_i      (clk),
      .rst_ni     (reset),
      .btn_i      (btn[i]),
      .estable_o  (estable[i]),
      .pulsacion_o(pulsacion[i])
    );
  end

`ifdef CONTROL_BOTONES_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] RPT_DELAY_MAX = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_RATE_MAX  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] rpt_cnt_q [NUM_DIRS];
  logic [RW-1:0] rpt_cnt_d [NUM_DIRS];
  dir_vec_t      rpt_first_q, rpt_first_d;

  // First interval after a press is REPEAT_DELAY, later ones REPEAT_RATE.
  always_comb begin
    for (int i = 0; i < NUM_DIRS; i++) begin
      rpt_cnt_d[i]   = '0;
      rpt_first_d[i] = rpt_first_q[i];
      repetir[i]     = 1'b0;
      if (pulsacion[i]) begin
        rpt_first_d[i] = 1'b1;
      end else if (estable[i]) begin
        if (rpt_cnt_q[i] == (rpt_first_q[i] ? RPT_DELAY_MAX : RPT_RATE_MAX)) begin
          repetir[i]     = 1'b1;
          rpt_first_d[i] = 1'b0;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DIRS; i++) rpt_cnt_q[i] <= '0;
      rpt_first_q <= '0;
    end else begin
      for (int i = 0; i < NUM_DIRS; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  assign repetir = '0;
`endif

  // New requests are OR-ed in after the grant is cleared, so a set beats a clear.
  always_comb begin
    salida_d = '0;
    pend_d   = '0;
    if (habilitar) begin
      for (int i = NUM_DIRS - 1; i >= 0; i--) begin
        if (pend_q[i] && (salida_d == '0)) salida_d[i] = 1'b1;
      end
      pend_d = (pend_q & ~salida_d) | pulsacion | repetir;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q   <= '0;
      salida_q <= '0;
    end else begin
      pend_q   <= pend_d;
      salida_q <= salida_d;
    end
  end

  assign arriba      = salida_q[DIR_ARRIBA];
  assign abajo       = salida_q[DIR_ABAJO];
  assign derecha     = salida_q[DIR_DERECHA];
  assign izquierda   = salida_q[DIR_IZQUIERDA];
  assign btn_estable = estable;

endmodule

// File: tb/tb_control_botones.sv
// Scoreboard bench for control_botones: directed scenarios plus random button
// activity, checked against a window-based reference model of the buttons.
module tb_control_botones;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  typedef struct {
    int         e;
    logic [3:0] v;
  } pulse_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       habilitar;
  logic [3:0] btn;
  logic       arriba, abajo, derecha, izquierda;
  logic [3:0] btn_estable;

  int tests = 0;
  int fails = 0;
  int edgeN = 0;

  pulse_t expQ[$];
  pulse_t seenLog[$];
  pulse_t wantLog[$];

  int         hist[4][$];
  int         lastFlip[4];
  int         lastPress[4];
  int         k;
  logic [3:0] mStable;
  logic [3:0] mPend;

  control_botones #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .habilitar  (habilitar),
    .btn        (btn),
    .arriba     (arriba),
    .abajo      (abajo),
    .derecha    (derecha),
    .izquierda  (izquierda),
    .btn_estable(btn_estable)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted after D consecutive samples that
  // differ from the stable level, seen two edges late through the synchroniser.
  always @(posedge clk) begin
    logic [3:0] prev, press, rep, grant;
    edgeN++;
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        hist[i].delete();
        lastFlip[i]  = -1000;
        lastPress[i] = -1000;
      end
      mStable = '0;
      mPend   = '0;
      k       = 0;
    end else begin
      prev  = mStable;
      press = '0;
      rep   = '0;
      grant = '0;
      for (int i = 0; i < 4; i++) begin
        bit allSame;
        hist[i].push_back(int'(btn[i]));
        if ((k - lastFlip[i] >= D) && (k - D - 1 >= 0)) begin
          allSame = 1'b1;
          for (int j = k - D - 1; j <= k - 2; j++)
            if (hist[i][j] != int'(!prev[i])) allSame = 1'b0;
          if (allSame) begin
            mStable[i]  = !prev[i];
            lastFlip[i] = k;
            if (mStable[i]) begin
              press[i]     = 1'b1;
              lastPress[i] = k;
            end
          end
        end
`ifdef CONTROL_BOTONES_AUTO_REPEAT_EN
        if (prev[i] && !press[i] && (k - lastPress[i] >= RD) &&
            ((k - lastPress[i] - RD) % RR == 0))
          rep[i] = 1'b1;
`endif
      end
      if (habilitar) begin
        for (int i = 3; i >= 0; i--)
          if (mPend[i] && grant == '0) grant[i] = 1'b1;
        mPend = (mPend & ~grant) | press | rep;
        if (grant != '0) expQ.push_back('{e: edgeN, v: grant});
      end else begin
        mPend = '0;
      end
      k++;
    end
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edgeN);
    end
  endtask

  // Monitor: pops the scoreboard whenever a pulse is due or one appears.
  always @(negedge clk) begin
    logic [3:0] obs, want;
    obs = {arriba, abajo, derecha, izquierda};
    if (!reset) begin
      checkOutput("reset_outputs", int'({obs, btn_estable}), 0);
    end else begin
      while (expQ.size() != 0 && expQ[0].e < edgeN) begin
        checkOutput("missed_pulse_edge", expQ[0].e, -1);
        void'(expQ.pop_front());
      end
      want = '0;
      if (expQ.size() != 0 && expQ[0].e == edgeN) want = expQ.pop_front().v;
      checkOutput("pulse", int'(obs), int'(want));
      checkOutput("btn_estable", int'(btn_estable), int'(mStable));
      if (obs != '0) seenLog.push_back('{e: edgeN, v: obs});
    end
  end

  task automatic applyStimulus(input logic [3:0] b, input logic h);
    btn       = b;
    habilitar = h;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic checkLog(input string name);
    checkOutput({name, "_count"}, seenLog.size(), wantLog.size());
    for (int i = 0; i < seenLog.size() && i < wantLog.size(); i++) begin
      checkOutput({name, "_edge"}, seenLog[i].e, wantLog[i].e);
      checkOutput({name, "_dir"}, int'(seenLog[i].v), int'(wantLog[i].v));
    end
    seenLog.delete();
    wantLog.delete();
  endtask

  initial begin
    int base, kEdge;
    logic [3:0] rb;
    logic rh;

    reset = 1'b0;
    applyStimulus(4'b0000, 1'b1);
    waitEdges(3);
    checkOutput("reset_estable", int'(btn_estable), 0);
    reset = 1'b1;
    waitEdges(5);
    seenLog.delete();

    // Clean press on arriba
    base = edgeN + 1;
    applyStimulus(4'b1000, 1'b1);
    waitEdges(5);
    checkOutput("t1_estable_before", int'(btn_estable[3]), 0);
    waitEdges(1);
    checkOutput("t1_estable_after", int'(btn_estable[3]), 1);
    waitEdges(6);
    applyStimulus(4'b0000, 1'b1);
    waitEdges(20);
    wantLog.push_back('{e: base + 6, v: 4'b1000});
    checkLog("t1");

    // Short glitch, then bounce followed by a steady hold on derecha
    applyStimulus(4'b0010, 1'b1);
    waitEdges(3);
    applyStimulus(4'b0000, 1'b1);
    waitEdges(20);
    base = edgeN + 1;
    for (int j = 0; j < 6; j++) begin
      applyStimulus((j % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1);
      waitEdges(1);
    end
    kEdge = base + 6;
    applyStimulus(4'b0010, 1'b1);
    waitEdges(12);
    applyStimulus(4'b0000, 1'b1);
    waitEdges(20);
    wantLog.push_back('{e: kEdge + 6, v: 4'b0010});
    checkLog("t2");

    // Simultaneous arriba and izquierda
    base = edgeN + 1;
    applyStimulus(4'b1001, 1'b1);
    waitEdges(12);
    applyStimulus(4'b0000, 1'b1);
    waitEdges(20);
    wantLog.push_back('{e: base + 6, v: 4'b1000});
    wantLog.push_back('{e: base + 7, v: 4'b0001});
    checkLog("t3");

    // Press while disabled, enable while still held
    applyStimulus(4'b0100, 1'b0);
    waitEdges(10);
    applyStimulus(4'b0100, 1'b1);
    waitEdges(4);
    applyStimulus(4'b0000, 1'b1);
    waitEdges(20);
    checkLog("t4");

    // Reset in the middle of an izquierda press
    base = edgeN + 1;
    applyStimulus(4'b0001, 1'b1);
    waitEdges(6);
    reset = 1'b0;
    #1;
    checkOutput("t5_reset_async", int'({arriba, abajo, derecha, izquierda, btn_estable}), 0);
    waitEdges(3);
    reset = 1'b1;
    waitEdges(12);
    applyStimulus(4'b0000, 1'b1);
    waitEdges(25);
    wantLog.push_back('{e: base + 15, v: 4'b0001});
    checkLog("t5");

    // Long hold on arriba
    base = edgeN + 1;
    applyStimulus(4'b1000, 1'b1);
    waitEdges(41);
    applyStimulus(4'b0000, 1'b1);
    waitEdges(30);
    wantLog.push_back('{e: base + 6, v: 4'b1000});
`ifdef CONTROL_BOTONES_AUTO_REPEAT_EN
    wantLog.push_back('{e: base + 26, v: 4'b1000});
    wantLog.push_back('{e: base + 34, v: 4'b1000});
    wantLog.push_back('{e: base + 42, v: 4'b1000});
`endif
    checkLog("t6");

    // Random button activity with occasional enable changes
    rb = 4'b0000;
    rh = 1'b1;
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(9) == 0) rb[i] = ~rb[i];
      if ($urandom_range(49) == 0) rh = ~rh;
      applyStimulus(rb, rh);
      waitEdges(1);
    end
    applyStimulus(4'b0000, 1'b1);
    waitEdges(60);
    checkOutput("scoreboard_drain", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_botones.md
Name: control_botones

Overview:
- Front end that drives the cursor mover's direction inputs (arriba/abajo/derecha/izquierda) from four raw board push-buttons.
- Per button, the block:
  - synchronises the raw input;
  - debounces it;
  - turns each debounced press into exactly one single-cycle move pulse.
- Arbitrates simultaneous presses so at most one direction pulse is high per cycle.
- Sits between the board pins and the cursor/position logic in the grid game.

Parameters:
- DEBOUNCE_CYCLES, default 500000: consecutive cycles a synchronised level must differ from the stable level before it is accepted (10 ms at 50 MHz). Must be >= 2.
- REPEAT_DELAY, default 25000000: cycles from press acceptance to the first auto-repeat. Used only with AUTO_REPEAT_EN.
- REPEAT_RATE, default 10000000: cycles between subsequent auto-repeats. Used only with AUTO_REPEAT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- habilitar  in  1  move enable; when low, no pulses are issued and pending moves are discarded
- btn  in  4  raw buttons, active-high, asynchronous. [3]=arriba, [2]=abajo, [1]=derecha, [0]=izquierda
- arriba  out  1  one-cycle move-up pulse
- abajo  out  1  one-cycle move-down pulse
- derecha  out  1  one-cycle move-right pulse
- izquierda  out  1  one-cycle move-left pulse
- btn_estable  out  4  debounced button levels (debug/LED)

Behaviour:
- Reset (reset low, asynchronous): all outputs, synchronisers, stable levels, counters and pending bits go to 0. The same applies on reset mid-press. After release, a still-held button is treated as a new press once debounced.
- Synchroniser: two flops per button (sync1, sync2).
- Debounce, per button:
  - On each edge where sync2 != stable, cnt increments.
  - When cnt == DEBOUNCE_CYCLES-1 and sync2 still differs, stable <= sync2 and cnt <= 0.
  - Any edge with sync2 == stable clears cnt.
  - cnt width is $clog2(DEBOUNCE_CYCLES).
- Press event: a stable 0->1 transition sets pending[i] on that same edge. A 1->0 transition (release) produces no event.
- Arbiter:
  - Each edge, if habilitar = 1, the highest-priority pending bit is registered to its output and cleared.
  - Priority: arriba > abajo > derecha > izquierda.
  - Outputs are registered and one-hot-or-zero. No output stays high for two consecutive cycles unless re-triggered.
- Latency: taking the first edge that samples btn high as edge 0:
  - stable flips at edge DEBOUNCE_CYCLES+1;
  - the output rises at edge DEBOUNCE_CYCLES+2 and falls on the next edge.
- Simultaneous presses: the pulses are emitted on consecutive cycles in priority order. Opposing directions are not suppressed.
- If a pending bit is being set on the same edge it is being cleared, the set wins.
- habilitar = 0: all pending bits are cleared each edge and outputs are 0. Debounce still runs, so raising habilitar while a button is held issues no pulse.
- btn_estable equals the stable levels directly.

Optional Feature:
- Macro: CONTROL_BOTONES_AUTO_REPEAT_EN.
- Defined: each button has a repeat counter, cleared on its press event and advancing while stable = 1. pending[i] is re-set at edges E+REPEAT_DELAY, E+REPEAT_DELAY+REPEAT_RATE, E+REPEAT_DELAY+2*REPEAT_RATE, and so on, where E is the press-acceptance edge. Repeats stop when stable falls.
- Undefined: exactly one pulse per press. No repeat counters are synthesised and the REPEAT_* parameters are ignored.

Decomposition:
- Package control_botones_pkg holds:
  - NUM_DIRS = 4;
  - index constants DIR_ARRIBA = 3, DIR_ABAJO = 2, DIR_DERECHA = 1, DIR_IZQUIERDA = 0;
  - typedef dir_vec_t as logic [NUM_DIRS-1:0].
- Sub-module antirrebote, instantiated four times, contains the synchroniser, debounce counter, stable level and a one-cycle press-event output.
- The top level holds the pending bits, the arbiter and the repeat logic.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
1. Clean press: btn[3] high from edge 0 for 12 cycles, then low -> arriba high only in the cycle after edge 6; btn_estable[3] rises at edge 5; no pulse on release; other outputs stay 0.
2. Glitch and bounce: btn[1] high for 3 cycles, then low -> no pulse. Then btn[1] toggling each cycle for 6 cycles, then held from edge k -> exactly one derecha pulse, at edge k+6.
3. Simultaneous: btn[3] and btn[0] rise together at edge 0 -> arriba at edge 6, izquierda at edge 7, never both high.
4. Enable gating: habilitar = 0 while btn[2] is pressed and held, then habilitar = 1 at edge 10 with btn[2] still held -> no abajo pulse at any time.
5. Reset mid-operation: reset low at edge 5 of a btn[0] press, released at edge 8 with btn[0] still held -> all outputs 0 during reset; izquierda pulses at edge 8+1+6.
6. Auto-repeat, macro defined: btn[3] held from edge 0 to edge 40 -> arriba pulses at edges 6, 26, 34, 42 only. With the macro undefined -> pulse at edge 6 only.
